axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin AR arbiter with ID-based R routing and outstanding tracking
module axi_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IDX_W           = 2,
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int OUTST_WIDTH     = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           s_ar_valid,
  output logic [NUM_REQ-1:0]                           s_ar_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]                 s_ar_addr,
  input  logic [NUM_REQ*BURST_LEN_WIDTH-1:0]           s_ar_len,
  input  logic [NUM_REQ*(TID_WIDTH-IDX_W)-1:0]         s_ar_id,
  output logic                                         m_ar_valid,
  input  logic                                         m_ar_ready,
  output logic [ADDR_BITS-1:0]                         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]                   m_ar_len,
  output logic [TID_WIDTH-1:0]                         m_ar_id,
  input  logic                                         m_r_valid,
  output logic                                         m_r_ready,
  input  logic                                         m_r_last,
  input  logic [DATA_WIDTH-1:0]                        m_r_data,
  input  logic [TID_WIDTH-1:0]                         m_r_id,
  output logic [NUM_REQ-1:0]                           s_r_valid,
  input  logic [NUM_REQ-1:0]                           s_r_ready,
  output logic                                         s_r_last,
  output logic [DATA_WIDTH-1:0]                        s_r_data,
  output logic [TID_WIDTH-IDX_W-1:0]                   s_r_id,
  output logic [NUM_REQ*OUTST_WIDTH-1:0]               outst_cnt,
  output logic                                         err_unexp_r
);

  localparam int UID_W = TID_WIDTH - IDX_W;
  localparam logic [OUTST_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ARB, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       win;
  logic                   found;
  logic [NUM_REQ-1:0]     elig;
  logic [NUM_REQ-1:0]     ar_hs;
  logic [NUM_REQ-1:0]     cnt_inc;
  logic [NUM_REQ-1:0]     cnt_dec;
  logic [OUTST_WIDTH-1:0] cnt [NUM_REQ];
  logic [IDX_W-1:0]       r_idx;
  logic                   r_hs;
  logic                   m_ar_hs;

  // A requester may compete only while it has room for one more outstanding burst
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = s_ar_valid[i] && (cnt[i] != CNT_MAX);
    end
  end

  // Round-robin search from rr_ptr; scanning downward lets the nearest hit win
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[rr_ptr + IDX_W'(k)]) begin
        found = 1'b1;
        win   = rr_ptr + IDX_W'(k);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // FSM next state: grab a winner in ARB, wait for the downstream handshake in HOLD
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (found)      state_nxt = HOLD;
      HOLD: if (m_ar_ready) state_nxt = ARB;
      default:              state_nxt = ARB;
    endcase
  end

  // FSM outputs: one-hot upstream ready in ARB, downstream valid exactly in HOLD
  always_comb begin
    s_ar_ready = '0;
    m_ar_valid = (state == HOLD);
    if ((state == ARB) && found && !rst) s_ar_ready[win] = 1'b1;
  end

  assign ar_hs   = s_ar_ready & s_ar_valid;
  assign m_ar_hs = m_ar_valid & m_ar_ready;

  // Capture the winning request; the requester index rides in the top ID bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ar_addr <= '0;
      m_ar_len  <= '0;
      m_ar_id   <= '0;
    end else if ((state == ARB) && found) begin
      m_ar_addr <= s_ar_addr[win*ADDR_BITS +: ADDR_BITS];
      m_ar_len  <= s_ar_len[win*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
      m_ar_id   <= {win, s_ar_id[win*UID_W +: UID_W]};
    end
  end

  // Advance the round-robin pointer past the granted requester only once it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rr_ptr <= '0;
    else if (m_ar_hs) rr_ptr <= m_ar_id[TID_WIDTH-1 -: IDX_W] + IDX_W'(1);
  end

  // R routing is purely combinational, selected by the requester index in the ID
  always_comb begin
    r_idx            = m_r_id[TID_WIDTH-1 -: IDX_W];
    s_r_valid        = '0;
    s_r_valid[r_idx] = m_r_valid;
    m_r_ready        = s_r_ready[r_idx];
    r_hs             = m_r_valid && s_r_ready[r_idx];
  end

  assign s_r_last = m_r_last;
  assign s_r_data = m_r_data;
  assign s_r_id   = m_r_id[UID_W-1:0];

  // Counter events; a last beat to an idle requester must not underflow
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = ar_hs[i];
      cnt_dec[i] = r_hs && m_r_last && (r_idx == IDX_W'(i)) && (cnt[i] != '0);
    end
  end

  // Per-requester outstanding-burst counters; simultaneous inc and dec cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt[i] <= cnt[i] + OUTST_WIDTH'(1);
        else if (cnt_dec[i] && !cnt_inc[i]) cnt[i] <= cnt[i] - OUTST_WIDTH'(1);
      end
    end
  end

  // Flatten counters onto the packed status port
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) outst_cnt[i*OUTST_WIDTH +: OUTST_WIDTH] = cnt[i];
  end

  // Sticky flag for any R beat that reaches a requester with nothing outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_unexp_r <= 1'b0;
    else if (r_hs && (cnt[r_idx] == '0))  err_unexp_r <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_ar_valid, s_ar_ready;
  logic [63:0] s_ar_addr;
  logic [31:0] s_ar_len;
  logic [23:0] s_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id;
  logic [3:0]  s_r_valid, s_r_ready;
  logic        s_r_last;
  logic [7:0]  s_r_data;
  logic [5:0]  s_r_id;
  logic [11:0] outst_cnt;
  logic        err_unexp_r;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ar_q[$];
  logic [31:0] r_q[$];
  int order[5] = '{0, 1, 2, 3, 0};

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .s_r_data(s_r_data), .s_r_id(s_r_id),
    .outst_cnt(outst_cnt), .err_unexp_r(err_unexp_r)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_of(input int i);
    return int'(outst_cnt[i*3 +: 3]);
  endfunction

  function automatic logic [31:0] ar_exp(input int r);
    return {s_ar_addr[r*16 +: 16], s_ar_len[r*8 +: 8], 2'(r), s_ar_id[r*6 +: 6]};
  endfunction

  task automatic idle_inputs();
    s_ar_valid = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every downstream AR handshake and every R handshake is popped and compared
  always @(negedge clk) begin
    #2;
    if (!rst && m_ar_valid && m_ar_ready) begin
      if (ar_q.size() == 0) check("ar_unexpected", {m_ar_addr, m_ar_len, m_ar_id}, 32'hFFFF_FFFF);
      else check("ar_beat", {m_ar_addr, m_ar_len, m_ar_id}, ar_q.pop_front());
    end
    if (m_r_valid && m_r_ready) begin
      if (r_q.size() == 0) check("r_unexpected", 32'({s_r_valid, s_r_last, s_r_id, s_r_data}), 32'hFFFF_FFFF);
      else check("r_beat", 32'({s_r_valid, s_r_last, s_r_id, s_r_data}), r_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
    for (int i = 0; i < 4; i++) begin
      s_ar_addr[i*16 +: 16] = 16'h1000 + 16'(i);
      s_ar_len[i*8 +: 8]    = 8'(i);
      s_ar_id[i*6 +: 6]     = 6'(i + 8);
    end

    // Reset state; AR ready held low, R still routed
    @(negedge clk);
    s_ar_valid = 4'hF; s_r_ready = 4'hF;
    m_r_valid = 1'b1; m_r_id = 8'h80; m_r_data = 8'h11; m_r_last = 1'b0;
    r_q.push_back(32'({4'b0100, 1'b0, 6'h00, 8'h11}));
    #2;
    check("rst_ar_ready", 32'(s_ar_ready), 32'h0);
    check("rst_m_ar_valid", 32'(m_ar_valid), 32'h0);
    check("rst_m_ar", {m_ar_addr, m_ar_len, m_ar_id}, 32'h0);
    check("rst_outst", 32'(outst_cnt), 32'h0);
    check("rst_err", 32'(err_unexp_r), 32'h0);
    check("rst_r_route", 32'(s_r_valid), 32'h4);
    do_reset();

    // Scenario 1: all requesters valid, round-robin 0,1,2,3,0 one per two cycles
    for (int g = 0; g < 5; g++) ar_q.push_back(ar_exp(order[g]));
    m_ar_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_ar_valid = (c < 9) ? 4'hF : 4'h0;
      #2;
      check("s1_ar_ready", 32'(s_ar_ready), (c % 2 == 0) ? 32'(1 << order[c/2]) : 32'h0);
      check("s1_m_ar_valid", 32'(m_ar_valid), 32'(c % 2));
    end
    @(negedge clk); #2;
    check("s1_q_empty", 32'(ar_q.size()), 32'h0);
    check("s1_cnt0", 32'(cnt_of(0)), 32'd2);
    check("s1_cnt3", 32'(cnt_of(3)), 32'd1);

    // Scenario 2: requester 2 held in HOLD for three stalled cycles
    do_reset();
    s_ar_addr[2*16 +: 16] = 16'h5940; s_ar_len[2*8 +: 8] = 8'd0; s_ar_id[2*6 +: 6] = 6'd5;
    ar_q.push_back(32'h5940_0085);
    @(negedge clk);
    s_ar_valid = 4'b0100; #2;
    check("s2_ar_ready", 32'(s_ar_ready), 32'h4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_ar_valid = 4'b0000; #2;
      check("s2_hold_valid", 32'(m_ar_valid), 32'h1);
      check("s2_hold_id", 32'(m_ar_id), 32'h85);
      check("s2_hold_addr", 32'(m_ar_addr), 32'h5940);
      check("s2_hold_ready", 32'(s_ar_ready), 32'h0);
    end
    @(negedge clk);
    m_ar_ready = 1'b1; #2;
    @(negedge clk); #2;
    check("s2_valid_drop", 32'(m_ar_valid), 32'h0);
    check("s2_cnt2", 32'(cnt_of(2)), 32'd1);
    check("s2_q_empty", 32'(ar_q.size()), 32'h0);

    // Scenario 3: requester 0 saturates at 7 outstanding and is masked
    do_reset();
    m_ar_ready = 1'b1;
    for (int g = 0; g < 7; g++) ar_q.push_back(ar_exp(0));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      s_ar_valid = 4'b0001; #2;
      if (c % 2 == 0) check("s3_grant0", 32'(s_ar_ready), 32'h1);
    end
    ar_q.push_back(ar_exp(1));
    @(negedge clk);
    s_ar_valid = 4'b0011; #2;
    check("s3_cnt0_max", 32'(cnt_of(0)), 32'd7);
    check("s3_masked_grant1", 32'(s_ar_ready), 32'h2);
    @(negedge clk);
    s_ar_valid = 4'b0001; #2;
    @(negedge clk); #2;
    check("s3_masked_none", 32'(s_ar_ready), 32'h0);
    @(negedge clk);
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 8'h03; m_r_data = 8'h3C; s_r_ready = 4'hF;
    r_q.push_back(32'({4'b0001, 1'b1, 6'h03, 8'h3C}));
    #2;
    check("s3_r_route", 32'(s_r_valid), 32'h1);
    check("s3_still_masked", 32'(s_ar_ready), 32'h0);
    @(negedge clk);
    m_r_valid = 1'b0; m_r_last = 1'b0;
    ar_q.push_back(ar_exp(0));
    #2;
    check("s3_cnt0_dec", 32'(cnt_of(0)), 32'd6);
    check("s3_reenabled", 32'(s_ar_ready), 32'h1);
    @(negedge clk);
    s_ar_valid = 4'b0000; #2;

    // Scenario 4: 4-beat burst to requester 1 with a stall before beat 2
    do_reset();
    m_ar_ready = 1'b1;
    ar_q.push_back(ar_exp(1));
    @(negedge clk); s_ar_valid = 4'b0010; #2;
    @(negedge clk); s_ar_valid = 4'b0000; #2;
    @(negedge clk); #2;
    check("s4_cnt1_start", 32'(cnt_of(1)), 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        @(negedge clk);
        m_r_valid = 1'b1; m_r_id = 8'h45; m_r_data = 8'hA2; m_r_last = 1'b0; s_r_ready = 4'b1101;
        #2;
        check("s4_stall_ready", 32'(m_r_ready), 32'h0);
        check("s4_stall_valid", 32'(s_r_valid), 32'h2);
      end
      @(negedge clk);
      m_r_valid = 1'b1; m_r_id = 8'h45; m_r_data = 8'hA0 + 8'(b);
      m_r_last = (b == 3); s_r_ready = 4'b0010;
      r_q.push_back(32'({4'b0010, (b == 3), 6'h05, 8'hA0 + 8'(b)}));
      #2;
      check("s4_beat_valid", 32'(s_r_valid), 32'h2);
      check("s4_beat_ready", 32'(m_r_ready), 32'h1);
      check("s4_beat_id", 32'(s_r_id), 32'h5);
      check("s4_cnt_hold", 32'(cnt_of(1)), 32'd1);
    end
    @(negedge clk);
    m_r_valid = 1'b0; m_r_last = 1'b0; #2;
    check("s4_cnt1_end", 32'(cnt_of(1)), 32'd0);

    // Scenario 5: unexpected R to requester 3
    @(negedge clk);
    m_r_valid = 1'b1; m_r_id = 8'hC1; m_r_last = 1'b1; m_r_data = 8'h77; s_r_ready = 4'b1000;
    r_q.push_back(32'({4'b1000, 1'b1, 6'h01, 8'h77}));
    #2;
    check("s5_route", 32'(s_r_valid), 32'h8);
    check("s5_ready", 32'(m_r_ready), 32'h1);
    check("s5_err_before", 32'(err_unexp_r), 32'h0);
    @(negedge clk);
    m_r_valid = 1'b0; m_r_last = 1'b0; #2;
    check("s5_err_set", 32'(err_unexp_r), 32'h1);
    check("s5_cnt3", 32'(cnt_of(3)), 32'd0);
    @(negedge clk); #2;
    check("s5_err_sticky", 32'(err_unexp_r), 32'h1);

    // Scenario 6: reset asserted mid-HOLD drops the pending AR
    s_ar_addr[3*16 +: 16] = 16'hBEEF; s_ar_len[3*8 +: 8] = 8'd3; s_ar_id[3*6 +: 6] = 6'h2A;
    m_ar_ready = 1'b0;
    @(negedge clk);
    s_ar_valid = 4'b1000; #2;
    check("s6_grant3", 32'(s_ar_ready), 32'h8);
    @(negedge clk);
    s_ar_valid = 4'b0000; #2;
    check("s6_hold", 32'(m_ar_valid), 32'h1);
    check("s6_cnt3", 32'(cnt_of(3)), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(m_ar_valid), 32'h0);
    check("s6_rst_outst", 32'(outst_cnt), 32'h0);
    check("s6_rst_err", 32'(err_unexp_r), 32'h0);
    check("s6_rst_id", 32'(m_ar_id), 32'h0);
    @(negedge clk);
    rst = 1'b0; m_ar_ready = 1'b1; s_ar_valid = 4'hF;
    ar_q.push_back(ar_exp(0));
    #2;
    check("s6_restart0", 32'(s_ar_ready), 32'h1);
    @(negedge clk);
    s_ar_valid = 4'h0; #2;
    @(negedge clk); #2;
    check("end_ar_q", 32'(ar_q.size()), 32'h0);
    check("end_r_q", 32'(r_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
